// File: rtl/alu_iter_if.sv
// Request/response bundle for alu_iter: operands and opcode in, registered result and flags out.
interface alu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic [WIDTH-1:0] Result;
  logic             Negative;
  logic             Zero;
  logic             Carry;
  logic             OverFlow;

  modport master (
    output in_valid, A, B, ALUControl,
    input  in_ready, out_valid, Result, Negative, Zero, Carry, OverFlow
  );

  modport slave (
    input  in_valid, A, B, ALUControl,
    output in_ready, out_valid, Result, Negative, Zero, Carry, OverFlow
  );
endinterface

// File: rtl/alu_iter.sv
// ALU with single-cycle logic/arith ops and iterative shift-add multiply / restoring divide.
// One request in flight; results and flags are held until the next completion.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  alu_iter_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_negative;
  logic               r_zero;
  logic               r_carry;
  logic               r_overflow;

  logic               w_accept;
  logic               w_is_iter;
  logic               w_last;
  logic               w_load_single;
  logic               w_load_iter;

  assign w_accept      = bus.in_valid && r_in_ready;
  assign w_is_iter     = bus.ALUControl[3] && !bus.ALUControl[2];
  assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_load_single = w_accept && !w_is_iter;
  assign w_load_iter   = (r_state == CALC) && w_last;

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != CALC);
      r_out_valid <= (w_state_next == DONE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_state_next = w_is_iter ? CALC : DONE;
        else          w_state_next = IDLE;
      end
      CALC:    if (w_last) w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  // Single-cycle datapath: SUB and SLT share the A + ~B + 1 adder.
  logic               w_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [SUM_W-1:0]   w_sum;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_single_res;
  logic               w_single_c;
  logic               w_single_v;

  assign w_sub   = (bus.ALUControl == OP_SUB) || (bus.ALUControl == OP_SLT);
  assign w_b_eff = w_sub ? ~bus.B : bus.B;
  assign w_sum   = {1'b0, bus.A} + {1'b0, w_b_eff} + SUM_W'(w_sub);
  assign w_ovf   = (bus.A[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);

  always_comb begin
    w_single_res = '0;
    w_single_c   = 1'b0;
    w_single_v   = 1'b0;
    case (bus.ALUControl)
      OP_ADD, OP_SUB: begin
        w_single_res = w_sum[WIDTH-1:0];
        w_single_c   = w_sum[WIDTH];
        w_single_v   = w_ovf;
      end
      OP_AND:  w_single_res = bus.A & bus.B;
      OP_OR:   w_single_res = bus.A | bus.B;
      OP_XOR:  w_single_res = bus.A ^ bus.B;
      OP_SLT:  w_single_res = WIDTH'(w_sum[WIDTH-1] ^ w_ovf);
      OP_SLTU: w_single_res = WIDTH'(bus.A < bus.B);
      default: w_single_res = '0;
    endcase
  end

  // Iterative step: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [SUM_W-1:0]   w_mul_sum;
  logic [ACC_W-1:0]   w_mul_next;
  logic [SUM_W-1:0]   w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [ACC_W-1:0]   w_div_next;
  logic [ACC_W-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_iter_res;

  assign w_mul_sum  = {1'b0, r_acc[ACC_W-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[ACC_W-1:1]};
  assign w_trial    = {r_acc[ACC_W-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_b});
  assign w_diff     = w_trial[WIDTH-1:0] - r_b;
  assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  assign w_acc_next = r_op[1] ? w_div_next : w_mul_next;
  assign w_iter_res = r_op[0] ? w_acc_next[ACC_W-1:WIDTH] : w_acc_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_b   <= '0;
      r_op  <= '0;
    end else if (w_accept && w_is_iter) begin
      r_cnt <= '0;
      r_acc <= {WIDTH'(0), bus.A};
      r_b   <= bus.B;
      r_op  <= bus.ALUControl[1:0];
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_acc_next;
    end
  end

  // Result and flags load only on the edge that enters DONE.
  logic [WIDTH-1:0]   w_res_next;
  assign w_res_next = w_load_iter ? w_iter_res : w_single_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_negative <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_load_single || w_load_iter) begin
      r_result   <= w_res_next;
      r_negative <= w_res_next[WIDTH-1];
      r_zero     <= (w_res_next == '0);
      r_carry    <= w_load_iter ? 1'b0 : w_single_c;
      r_overflow <= w_load_iter ? 1'b0 : w_single_v;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Result    = r_result;
  assign bus.Negative  = r_negative;
  assign bus.Zero      = r_zero;
  assign bus.Carry     = r_carry;
  assign bus.OverFlow  = r_overflow;
endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port A  input  WIDTH  first operand.
REQ-007 SHALL have port B  input  WIDTH  second operand.
REQ-008 SHALL have port ALUControl  input  4  opcode.
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse marking Result and the flags valid.
REQ-010 SHALL have port Result  output  WIDTH  registered result.
REQ-011 SHALL have ports Negative, Zero, Carry, OverFlow, each output, 1 bit, registered status flags.

Function
REQ-012 SHALL decode opcodes as follows: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 1000 MUL (low WIDTH bits of the unsigned product), 1001 MULHU (high WIDTH bits), 1010 DIVU, 1011 REMU.
REQ-013 SHALL produce Result 0 with latency 1 for any undefined opcode.
REQ-014 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1, capturing A, B and ALUControl internally.
REQ-015 SHALL not require A, B or ALUControl to remain stable after acceptance.
REQ-016 SHALL implement the states IDLE, CALC and DONE.
REQ-017 SHALL transition IDLE->DONE on acceptance of a single-cycle opcode, and IDLE->CALC on acceptance of an opcode from 1000 to 1011.
REQ-018 SHALL remain in CALC for exactly WIDTH cycles, driven by an iteration counter of $clog2(WIDTH)+1 bits, then transition to DONE.
REQ-019 SHALL hold out_valid=1 only while in DONE.
REQ-020 SHALL transition from DONE to CALC or DONE on a new acceptance, otherwise to IDLE.
REQ-021 SHALL drive in_ready=1 in IDLE and DONE and in_ready=0 in CALC, so back-to-back requests are accepted in DONE.
REQ-022 SHALL ignore in_valid while in CALC; the request is not queued.
REQ-023 SHALL give single-cycle opcodes a latency of 1: out_valid is asserted in the cycle after acceptance.
REQ-024 SHALL give iterative opcodes a latency of WIDTH+1: out_valid is asserted in cycle accept+WIDTH+1.
REQ-025 SHALL compute MUL and MULHU by a radix-2 shift-add over a 2*WIDTH-bit accumulator, one multiplier bit per CALC cycle.
REQ-026 SHALL compute DIVU and REMU by restoring division, one quotient bit per CALC cycle.
REQ-027 SHALL return quotient all-ones and remainder = A when dividing by zero, with no exception and unchanged latency.
REQ-028 SHALL form ADD/SUB as A+B or A+(~B)+1 in WIDTH+1 bits.
REQ-029 SHALL set Carry to the carry-out bit (for SUB, 1 = no borrow), and set OverFlow=1 when both operands have the same effective sign but the sum sign differs.
REQ-030 SHALL set Carry=0 and OverFlow=0 for every opcode other than ADD and SUB.
REQ-031 SHALL produce SLT/SLTU as zero-extended 0 or 1, with SLT correct under overflow (computed as sign XOR overflow).
REQ-032 SHALL compute Negative as Result[WIDTH-1] and Zero as (Result==0) for every opcode.
REQ-033 SHALL load Result and the flags in the same edge that enters DONE, and hold them unchanged until the next completion.

Reset
REQ-034 SHALL, while rst=1, force state IDLE, counter 0, in_ready=1, out_valid=0, Result 0, Negative=0, Zero=0, Carry=0, OverFlow=0.
REQ-035 SHALL let rst abort an in-flight CALC operation with no out_valid pulse.
REQ-036 SHALL give rst priority over an in_valid asserted in the same cycle, and drop that request.

Verification (WIDTH=32)
REQ-037 ADD 0x7FFFFFFF + 0x00000001 -> one cycle later out_valid=1, Result 0x80000000, Negative=1, OverFlow=1, Carry=0, Zero=0.
REQ-038 SUB 5 - 5, then SLT 0x80000000 vs 1 issued back-to-back in DONE -> Result 0 with Zero=1, Carry=1; then Result 1; out_valid high in two consecutive cycles.
REQ-039 MUL and then MULHU of 0xFFFFFFFF x 0xFFFFFFFF -> Result 0x00000001, then 0xFFFFFFFE; each out_valid exactly 33 cycles after acceptance; in_ready=0 throughout CALC.
REQ-040 DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234.
REQ-041 in_valid held high during CALC with a different opcode -> ignored; result reflects only the original operation.
REQ-042 rst asserted at CALC cycle 10 of a DIVU -> next cycle IDLE, all outputs at reset values, no out_valid; a following ADD 2+3 -> Result 5 after 1 cycle.
